// File: rtl/counter_cmd_pkg.sv
// Shared encodings for the counter command sequencer: op codes that match the
// shift register's s1s0 select, FSM states, and the FIFO entry width.
package counter_cmd_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SHR   = 2'b01,
    OP_SHL   = 2'b10,
    OP_COUNT = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int OP_W = 2;

  // A FIFO entry is {op, fill, len}.
  function automatic int cmd_width(input int len_w);
    return OP_W + 1 + len_w;
  endfunction

endpackage

// File: rtl/counter_cmd_seq_fifo.sv
// Synchronous DEPTH-entry command FIFO with push, pop, flush and an occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module cmd_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer feeding the 4-bit counter/shift stage: queues mode commands
// and plays each one back for cmd_len cycles with registered, bubble-free outputs.
module counter_cmd_seq
  import counter_cmd_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic                   cmd_fill,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   abort,
  output logic                   s1,
  output logic                   s0,
  output logic                   MSBin,
  output logic                   LSBin,
  output logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CW = cmd_width(LEN_W);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CW-1:0]    wdata;
  logic [CW-1:0]    rdata;
  op_t              head_op;
  logic             head_fill;
  logic [LEN_W-1:0] head_len;

  state_t           state, state_n;
  logic [LEN_W-1:0] remaining, rem_n;
  logic             s1_n, s0_n, msb_n, lsb_n, en_n, done_n, busy_n;
  logic             load;
  logic [LW-1:0]    lvl_n;

  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign wdata     = {cmd_op, cmd_fill, cmd_len};
  assign head_op   = op_t'(rdata[CW-1 -: OP_W]);
  assign head_fill = rdata[LEN_W];
  assign head_len  = rdata[LEN_W-1:0];

  cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Outputs are computed one cycle ahead so they are registered; a pop on the
  // final active cycle lets the next command start without a gap.
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    pop     = 1'b0;
    load    = 1'b0;
    s1_n    = 1'b0;
    s0_n    = 1'b0;
    msb_n   = 1'b0;
    lsb_n   = 1'b0;
    en_n    = 1'b0;
    done_n  = 1'b0;

    if (abort) begin
      state_n = ST_IDLE;
      rem_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) load = 1'b1;
        end
        ST_RUN: begin
          if (remaining == LEN_W'(1)) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
              rem_n   = '0;
            end
          end else begin
            rem_n  = remaining - LEN_W'(1);
            s1_n   = s1;
            s0_n   = s0;
            msb_n  = MSBin;
            lsb_n  = LSBin;
            en_n   = 1'b1;
            done_n = (remaining == LEN_W'(2));
          end
        end
        default: begin
          state_n = ST_IDLE;
          rem_n   = '0;
        end
      endcase
    end

    // A zero-length command retires in a single idle-looking cycle.
    if (load) begin
      pop = 1'b1;
      if (head_len == '0) begin
        state_n = ST_IDLE;
        rem_n   = '0;
        done_n  = 1'b1;
      end else begin
        state_n = ST_RUN;
        rem_n   = head_len;
        s1_n    = head_op[1];
        s0_n    = head_op[0];
        msb_n   = (head_op == OP_SHR) ? head_fill : 1'b0;
        lsb_n   = (head_op == OP_SHL) ? head_fill : 1'b0;
        en_n    = 1'b1;
        done_n  = (head_len == LEN_W'(1));
      end
    end

    lvl_n  = abort ? '0 : (level + LW'(push) - LW'(pop));
    busy_n = (state_n == ST_RUN) || (lvl_n != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      MSBin     <= 1'b0;
      LSBin     <= 1'b0;
      enable    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      s1        <= s1_n;
      s0        <= s0_n;
      MSBin     <= msb_n;
      LSBin     <= lsb_n;
      enable    <= en_n;
      done      <= done_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer sitting directly upstream of the 4-bit counter/shift-register stage. It accepts mode commands over a valid/ready handshake, buffers them in a small FIFO, and drives the counter's `s1`, `s0`, `MSBin`, `LSBin` and `enable` inputs for a programmed number of cycles per command. Commands play back-to-back with no bubble, so software-level sequences (count N, shift-left M, hold) run at full clock rate.

## Interface
- `LEN_W`, 8: width of the per-command run length.
- `DEPTH`, 4: command FIFO depth; must be a power of 2, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept.
- `cmd_op`  in  2  00 HOLD, 01 SHR (MSBin enters), 10 SHL (LSBin enters), 11 COUNT (parallel load of the adder result).
- `cmd_fill`  in  1  serial bit driven on MSBin (SHR) or LSBin (SHL).
- `cmd_len`  in  LEN_W  active cycles for this command; 0 means discard.
- `abort`  in  1  synchronous flush of FIFO and active command.
- `s1`, `s0`  out  1 each  mode select to the counter.
- `MSBin`, `LSBin`  out  1 each  serial inputs to the counter.
- `enable`  out  1  counter enable; high only during active cycles.
- `busy`  out  1  active command or FIFO non-empty.
- `done`  out  1  one-cycle pulse per retired command.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Idle values, also the reset values: `s1`=`s0`=0, `MSBin`=`LSBin`=0, `enable`=0, `done`=0, `busy`=0, `level`=0, `cmd_ready`=1.
- Push on the clock edge where `cmd_valid & cmd_ready`. `cmd_ready` = !full & !abort. It depends on occupancy only, so a full FIFO rejects a push even when a pop happens in the same cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the active registers, load `remaining`=`cmd_len`, and go to RUN.
  - RUN: outputs follow the active op and `enable`=1. `remaining` decrements every cycle.
    - On the final cycle (`remaining`=1), `done`=1.
    - If the FIFO is non-empty on the final cycle, pop the next command in the same edge and stay in RUN with no gap. Otherwise go to IDLE.
- Output mapping:
  - `s1`/`s0` equal `cmd_op` while active.
  - `MSBin`=`cmd_fill` only for SHR; `LSBin`=`cmd_fill` only for SHL; otherwise both are 0.
  - HOLD still asserts `enable`, with `s1s0`=00.
- `cmd_len`=0: the command is popped, `done` pulses for one cycle, and the outputs stay at idle values for that cycle. This costs one cycle and produces no active cycle.
- `abort`: at the next edge the FIFO empties, `level`=0, the FSM goes to IDLE and the outputs go to idle values. `done` is not pulsed for the aborted command. A push offered in the same cycle is refused.
- `reset` mid-run: all outputs and state clear immediately (asynchronously).
- FIFO pointers wrap modulo DEPTH. `level` counts 0..DEPTH.

## Timing
- Command pushed at edge E0 into an empty, idle block: it is popped at E1, and the first active cycle is E1..E2 (all outputs registered). Push-to-drive latency is 1 cycle.
- A command with `cmd_len`=N gives exactly N consecutive cycles with `enable`=1. `done` is high in the Nth of those cycles.
- Back-to-back commands: the first active cycle of command B directly follows the last active cycle of command A.
- `busy` is registered and falls in the first cycle where the FIFO is empty and the FSM is in IDLE.

## Structure
- Package `counter_cmd_pkg` holds:
  - op encodings (`OP_HOLD`, `OP_SHR`, `OP_SHL`, `OP_COUNT`), matching the shift register's `s1s0` select;
  - FSM state encodings (`ST_IDLE`, `ST_RUN`);
  - the command entry width `2+1+LEN_W`.
- One sub-module, `cmd_fifo`: a synchronous DEPTH-entry FIFO with push/pop/flush and a level output. The sequencer FSM and output registers live in the top level.

## Test plan
- Reset, then push COUNT with len=3 → `enable`=1 for exactly 3 cycles starting one cycle after the push, `s1s0`=11, `done` high in the 3rd cycle. A counter model driven by these outputs advances 0→3.
- Push SHL fill=1 len=2, then SHR fill=0 len=1 on consecutive cycles → 3 contiguous active cycles with no gap. `LSBin`=1 for the first 2 cycles, then `s1s0`=01 with `MSBin`=0, and 2 `done` pulses.
- Push 4 commands with len=5 while running → `cmd_ready`=0 when `level`=4; a 5th valid is held off until a pop, and no command is lost.
- Push len=0 → one `done` pulse, `enable` never asserted, back to IDLE.
- Abort on the 2nd active cycle of len=6 with 2 queued → outputs idle at the next edge, `level`=0, no `done`, and a push offered in the abort cycle is refused.
- Assert `reset` mid-RUN, asynchronously between edges → outputs drop to 0 without waiting for an edge, and `level`=0.
